// File: rtl/cache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_fill_ctrl
//
// Sequencing controller for the 32-entry shift-register load lookup table in
// the memory path. It takes one CPU load/store at a time:
//   load  : probe the lookup table; on a hit answer from it, on a miss read
//           the backing memory and shift the result into the table.
//   store : write through to memory, then shift the stored word into the
//           table so later loads of the same address/tag see it.
// Memory accesses that are not acknowledged within MEM_TIMEOUT cycles are
// abandoned and answered with RESP_ERR (MEM_TIMEOUT = 0 waits forever).
//
// Optional build macro: CACHE_STORE_FLUSH_EN
//   When defined, a completed store first clears the whole lookup table
//   (one FLUSH cycle with LK_CLR = 1) before inserting the stored word, so
//   entries of the same address under other size/sign tags cannot go stale.
//
// Ports:
//   CLK, RST                 clock (rising edge), asynchronous active-high reset
//   REQ_VALID/READY          CPU request handshake (READY only in IDLE)
//   REQ_WE/ADDR/SIGN/OFFS/WDATA  request fields, captured on acceptance
//   RESP_VALID/READY         response handshake, response held until READY
//   RESP_DATA, RESP_ERR      load data (0 for stores / errors), timeout flag
//   LK_ADDR, LK_DIN          lookup-table address and {sign, offs, data} entry
//   LK_WE, LK_CLR            shift-in strobe, synchronous clear of the table
//   LK_DOUT, LK_FOUND        lookup-table hit data and hit flag
//   MEM_REQ/WE/ADDR/OFFS/WDATA  backing-memory request, held until MEM_ACK
//   MEM_ACK, MEM_RDATA       single-cycle completion with read data
// -----------------------------------------------------------------------------
module cache_fill_ctrl #(
   parameter int OFFS_W      = 3,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ_VALID,
   output logic              REQ_READY,
   input  logic              REQ_WE,
   input  logic [31:0]       REQ_ADDR,
   input  logic              REQ_SIGN,
   input  logic [OFFS_W-1:0] REQ_OFFS,
   input  logic [31:0]       REQ_WDATA,
   output logic              RESP_VALID,
   input  logic              RESP_READY,
   output logic [31:0]       RESP_DATA,
   output logic              RESP_ERR,
   output logic [31:0]       LK_ADDR,
   output logic [32+OFFS_W:0] LK_DIN,
   output logic              LK_WE,
   output logic              LK_CLR,
   input  logic [31:0]       LK_DOUT,
   input  logic              LK_FOUND,
   output logic              MEM_REQ,
   output logic              MEM_WE,
   output logic [31:0]       MEM_ADDR,
   output logic [OFFS_W-1:0] MEM_OFFS,
   output logic [31:0]       MEM_WDATA,
   input  logic              MEM_ACK,
   input  logic [31:0]       MEM_RDATA
);

   // The counter only has to reach MEM_TIMEOUT-1: MEM_REQ is high for the
   // cycles where the count is 0 .. MEM_TIMEOUT-1.
   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST =
      (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

   // ST_PROBE is the cycle in which the captured address is presented to the
   // table; its hit flag is sampled one cycle later in ST_LOOKUP, which gives
   // the two-edge hit latency from acceptance to RESP_VALID.
   typedef enum logic [3:0] {
      ST_INIT,
      ST_IDLE,
      ST_PROBE,
      ST_LOOKUP,
      ST_MEM_RD,
      ST_MEM_WR,
      ST_FILL,
`ifdef CACHE_STORE_FLUSH_EN
      ST_FLUSH,
`endif
      ST_RESP
   } state_t;

   state_t            state_reg;
   logic [31:0]       addr_reg;
   logic              sign_reg;
   logic [OFFS_W-1:0] offs_reg;
   logic              we_reg;
   logic [31:0]       wdata_reg;
   logic [31:0]       fill_reg;
   logic [CNT_W-1:0]  tmo_cnt_reg;

   logic              req_ready_reg;
   logic              resp_valid_reg;
   logic [31:0]       resp_data_reg;
   logic              resp_err_reg;
   logic              lk_we_reg;
   logic              lk_clr_reg;
   logic              mem_req_reg;
   logic              mem_we_reg;

   logic              tmo_expired;

   // An ACK in the expiry cycle is checked first, so it still counts as success.
   assign tmo_expired = (MEM_TIMEOUT != 0) && (tmo_cnt_reg == TMO_LAST);

   assign REQ_READY  = req_ready_reg;
   assign RESP_VALID = resp_valid_reg;
   assign RESP_DATA  = resp_data_reg;
   assign RESP_ERR   = resp_err_reg;
   assign LK_ADDR    = addr_reg;
   assign LK_DIN     = {sign_reg, offs_reg, fill_reg};
   assign LK_WE      = lk_we_reg;
   assign LK_CLR     = lk_clr_reg;
   assign MEM_REQ    = mem_req_reg;
   assign MEM_WE     = mem_we_reg;
   assign MEM_ADDR   = addr_reg;
   assign MEM_OFFS   = offs_reg;
   assign MEM_WDATA  = wdata_reg;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg      <= ST_INIT;
         addr_reg       <= '0;
         sign_reg       <= 1'b0;
         offs_reg       <= '0;
         we_reg         <= 1'b0;
         wdata_reg      <= '0;
         fill_reg       <= '0;
         tmo_cnt_reg    <= '0;
         req_ready_reg  <= 1'b0;
         resp_valid_reg <= 1'b0;
         resp_data_reg  <= '0;
         resp_err_reg   <= 1'b0;
         lk_we_reg      <= 1'b0;
         lk_clr_reg     <= 1'b1;
         mem_req_reg    <= 1'b0;
         mem_we_reg     <= 1'b0;
      end else begin
         // Table strobes are single-cycle pulses unless a transition sets them.
         lk_we_reg  <= 1'b0;
         lk_clr_reg <= 1'b0;

         case (state_reg)
            ST_INIT: begin
               state_reg     <= ST_IDLE;
               req_ready_reg <= 1'b1;
            end

            ST_IDLE: begin
               if (REQ_VALID) begin
                  addr_reg      <= REQ_ADDR;
                  sign_reg      <= REQ_SIGN;
                  offs_reg      <= REQ_OFFS;
                  we_reg        <= REQ_WE;
                  wdata_reg     <= REQ_WDATA;
                  req_ready_reg <= 1'b0;
                  if (REQ_WE) begin
                     state_reg   <= ST_MEM_WR;
                     mem_req_reg <= 1'b1;
                     mem_we_reg  <= 1'b1;
                     tmo_cnt_reg <= '0;
                  end else begin
                     state_reg <= ST_PROBE;
                  end
               end
            end

            ST_PROBE: begin
               state_reg <= ST_LOOKUP;
            end

            ST_LOOKUP: begin
               if (LK_FOUND) begin
                  resp_data_reg  <= LK_DOUT;
                  resp_err_reg   <= 1'b0;
                  resp_valid_reg <= 1'b1;
                  state_reg      <= ST_RESP;
               end else begin
                  state_reg   <= ST_MEM_RD;
                  mem_req_reg <= 1'b1;
                  mem_we_reg  <= 1'b0;
                  tmo_cnt_reg <= '0;
               end
            end

            ST_MEM_RD, ST_MEM_WR: begin
               if (MEM_ACK) begin
                  mem_req_reg <= 1'b0;
                  mem_we_reg  <= 1'b0;
                  if (we_reg) begin
                     resp_data_reg <= '0;
                     fill_reg      <= wdata_reg;
                  end else begin
                     resp_data_reg <= MEM_RDATA;
                     fill_reg      <= MEM_RDATA;
                  end
`ifdef CACHE_STORE_FLUSH_EN
                  if (we_reg) begin
                     state_reg  <= ST_FLUSH;
                     lk_clr_reg <= 1'b1;
                  end else begin
                     state_reg <= ST_FILL;
                     lk_we_reg <= 1'b1;
                  end
`else
                  state_reg <= ST_FILL;
                  lk_we_reg <= 1'b1;
`endif
               end else if (tmo_expired) begin
                  // Abandon the access: no table update, error response.
                  mem_req_reg    <= 1'b0;
                  mem_we_reg     <= 1'b0;
                  resp_err_reg   <= 1'b1;
                  resp_data_reg  <= '0;
                  resp_valid_reg <= 1'b1;
                  state_reg      <= ST_RESP;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
               end
            end

`ifdef CACHE_STORE_FLUSH_EN
            ST_FLUSH: begin
               state_reg <= ST_FILL;
               lk_we_reg <= 1'b1;
            end
`endif

            ST_FILL: begin
               state_reg      <= ST_RESP;
               resp_valid_reg <= 1'b1;
            end

            ST_RESP: begin
               if (RESP_READY) begin
                  resp_valid_reg <= 1'b0;
                  resp_err_reg   <= 1'b0;
                  resp_data_reg  <= '0;
                  req_ready_reg  <= 1'b1;
                  state_reg      <= ST_IDLE;
               end
            end

            default: begin
               state_reg      <= ST_INIT;
               lk_clr_reg     <= 1'b1;
               req_ready_reg  <= 1'b0;
               resp_valid_reg <= 1'b0;
               mem_req_reg    <= 1'b0;
               mem_we_reg     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
Sequencing controller for the 32-entry shift-register load lookup table in the RISC-V memory path. Accepts one CPU load/store at a time and probes the lookup table. On a load miss it fetches from the backing memory and shifts the result into the table. Stores are written through to memory.

Parameters:
OFFS_W, 3, width of the access-size/offset tag stored with each entry
MEM_TIMEOUT, 255, cycles to wait for MEM_ACK before aborting with RESP_ERR (0 = never)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
REQ_VALID  in  1  CPU request present
REQ_READY  out  1  controller can accept a request (IDLE only)
REQ_WE  in  1  1 = store, 0 = load
REQ_ADDR  in  32  byte address
REQ_SIGN  in  1  sign-extend flag for loads
REQ_OFFS  in  OFFS_W  access size/offset tag
REQ_WDATA  in  32  store data
RESP_VALID  out  1  response available; held until RESP_READY
RESP_READY  in  1  CPU consumes response
RESP_DATA  out  32  load data; 0 for stores
RESP_ERR  out  1  memory timeout on this transaction
LK_ADDR  out  32  lookup-table address
LK_DIN  out  33+OFFS_W  {sign, offs, data} to the lookup table
LK_WE  out  1  shift a new entry into the lookup table
LK_CLR  out  1  drives the lookup table's synchronous clear
LK_DOUT  in  32  lookup-table hit data
LK_FOUND  in  1  lookup-table hit flag
MEM_REQ  out  1  backing-memory request, held until ack
MEM_WE  out  1  memory write
MEM_ADDR  out  32  memory address
MEM_OFFS  out  OFFS_W  access size tag
MEM_WDATA  out  32  memory write data
MEM_ACK  in  1  single-cycle completion; MEM_RDATA valid in same cycle
MEM_RDATA  in  32  memory read data

Behaviour:
- Reset (async): state = INIT. All outputs 0 except LK_CLR = 1. Captured request registers and timeout counter cleared. Any in-flight memory transaction is abandoned; MEM_REQ drops immediately.
- INIT: lasts exactly 1 clock after RST deasserts (LK_CLR = 1), then go to IDLE.
- IDLE: REQ_READY = 1. On REQ_VALID, capture addr/sign/offs/we/wdata and go to LOOKUP (load) or MEM_WR (store).
- LK_ADDR and LK_DIN[32+OFFS_W:32] are always driven from captured registers. LK_DIN[31:0] = fill/store data.
- LOOKUP (1 cycle): sample LK_FOUND.
  - Hit: latch LK_DOUT into RESP_DATA, go to RESP.
  - Miss: go to MEM_RD.
  - Load hit latency: REQ accepted at edge N, RESP_VALID high after edge N+2.
- MEM_RD: MEM_REQ = 1, MEM_WE = 0; address and offs stable until ack.
  - On MEM_ACK: latch MEM_RDATA into RESP_DATA and fill register, go to FILL.
- FILL (1 cycle): LK_WE = 1 with LK_DIN = {sign, offs, fill data}, go to RESP.
- MEM_WR: MEM_REQ = 1, MEM_WE = 1, MEM_WDATA = captured wdata.
  - On MEM_ACK: go to FILL with fill data = wdata. The newest entry wins on later lookups; RESP_DATA = 0.
- RESP: RESP_VALID = 1 and data stable. On RESP_READY go to IDLE. A new request can be accepted in the following cycle (no same-cycle turnaround).
- Timeout: counter increments every cycle in MEM_RD/MEM_WR and clears on state entry.
  - On reaching MEM_TIMEOUT (nonzero): drop MEM_REQ, RESP_ERR = 1, RESP_DATA = 0, skip FILL, go to RESP.
  - MEM_ACK arriving in the same cycle as expiry counts as success.
- LK_WE and LK_CLR are never both 1. LK_WE pulses at most once per transaction.
- REQ_VALID outside IDLE is ignored (REQ_READY = 0).

Optional Feature:
- Macro: CACHE_STORE_FLUSH_EN.
- Defined: a store completion goes to FLUSH (LK_CLR = 1, 1 cycle), then FILL. This removes stale entries cached under other size/sign tags for the same address.
- Undefined: no FLUSH state; only the same-tag entry is inserted. Mixed-size aliasing of stored addresses is a software constraint.

Test Plan:
- Reset, then load 0x100 (word tag), memory returns 0xDEADBEEF after 3 cycles -> MEM_REQ held 3 cycles, LK_WE one pulse with LK_DIN data 0xDEADBEEF, RESP_DATA = 0xDEADBEEF.
- Repeat load 0x100 with same tag, LK_FOUND = 1, LK_DOUT = 0xDEADBEEF -> no MEM_REQ, RESP_VALID two cycles after acceptance.
- Store 0x100 = 0x12345678 -> MEM_WE = 1 with that data. FILL inserts 0x12345678. With CACHE_STORE_FLUSH_EN, LK_CLR pulses exactly one cycle before LK_WE.
- MEM_TIMEOUT = 4, memory never acks -> MEM_REQ drops after 4 cycles, RESP_ERR = 1, RESP_DATA = 0, no LK_WE.
- RESP_READY held low 5 cycles -> RESP_VALID and RESP_DATA stable, REQ_READY = 0 throughout.
- RST asserted mid-MEM_RD -> MEM_REQ = 0 immediately. LK_CLR = 1 for one cycle after release, then REQ_READY = 1.
